ema_coeff_sequencer: RTL
========================

// Module: ema_coeff_sequencer
// PURPOSE
//   Front-end controller for the single-channel EMA datapath in the AGC chain.
//   Throttles samples into the EMA so that no new sample enters until the previous
//   update has landed in the accumulator.
//   Selects the per-sample coefficient from a warm-up / attack / hold / release
//   schedule, and presents it aligned with the sample.
//   Sits between the detector stage and the EMA; EMA Filter_Out is fed back here.
// PARAMETERS
//   DWIDTH     27   sample width (signed), equals EMA data width
//   BWIDTH     18   coefficient width, equals EMA coefficient width
//   OUTWIDTH   48   EMA output width
//   WARMUP_LEN 64   samples issued with coef_warm after enable/restart (>=1)
//   HOLD_LEN   256  samples with coefficient 0 after the last attack (>=1)
//   ISSUE_GAP  4    minimum cycles between EMA issues (>=4, covers EMA loop latency)
// PORTS
//   clk          in   1         system clock
//   rst_n        in   1         asynchronous active-low reset
//   enable       in   1         run; 0 -> IDLE after in-flight gap expires
//   restart      in   1         1-cycle pulse: re-enter WARMUP, clear counters
//   coef_warm    in   BWIDTH    fast coefficient used in WARMUP
//   coef_attack  in   BWIDTH    coefficient when sample > EMA level
//   coef_release in   BWIDTH    coefficient when sample <= EMA level (RELEASE)
//   s_valid      in   1         upstream sample valid
//   s_ready      out  1         sequencer accepts sample this cycle
//   s_data       in   DWIDTH    upstream sample (signed)
//   ema_level    in   OUTWIDTH  EMA Filter_Out feedback
//   ema_valid    out  1         to EMA Valid, 1-cycle pulse per issued sample
//   ema_data     out  DWIDTH    to EMA Port_Data
//   ema_coeff    out  BWIDTH    to EMA Filter_Coefficient
//   state        out  2         0 IDLE, 1 WARMUP, 2 TRACK, 3 HOLD
// BEHAVIOUR
//   Reset: state=IDLE; s_ready, ema_valid, ema_data, ema_coeff = 0; counters = 0.
//   Accept = s_valid & s_ready. s_ready = enable & (state!=IDLE) & (gap_cnt==0).
//   On accept: gap_cnt <= ISSUE_GAP-1. It decrements to 0.
//     ema_valid=1 on the next cycle, with ema_data=s_data registered (latency 1).
//   ema_coeff is updated only in the cycle ema_valid=1. It then holds constant until
//     the next issue, because the EMA re-registers the coefficient.
//   Compare: signed s_data > signed ema_level[DWIDTH-1:0] -> attack.
//     The comparison uses the current ema_level, which is settled because ISSUE_GAP>=4.
//   FSM, evaluated per accepted sample:
//     IDLE   -> WARMUP when enable=1; warm_cnt=0.
//     WARMUP : coeff=coef_warm, warm_cnt++. Go to TRACK after the WARMUP_LEN-th sample.
//     TRACK  : attack  -> coeff=coef_attack, hold_cnt=HOLD_LEN, go to HOLD.
//              release -> coeff=coef_release.
//     HOLD   : attack  -> coeff=coef_attack, reload hold_cnt=HOLD_LEN.
//              else    -> coeff=0 (level frozen), hold_cnt--. Go to TRACK at 0.
//   restart (any state except IDLE) -> WARMUP, warm_cnt=0, hold_cnt=0.
//     Takes priority over the same-cycle sample decision; that sample uses coef_warm.
//   enable=0: no new accept. state -> IDLE once gap_cnt==0.
//     An already-registered ema_valid still completes.
//   restart with enable=0 is ignored.
//   Counters saturate; no wrap-around. ema_data passes through unmodified (no truncation).
//   Async reset mid-operation: all state cleared immediately. Any EMA issue in flight is dropped.
// CONFIGURATION
//   EMA_SEQ_FREEZE_EN defined: adds input port freeze (1 bit).
//     While freeze=1, samples are still accepted and issued with ema_coeff=0.
//     warm_cnt and hold_cnt are paused and state is unchanged.
//   Undefined: no freeze port; behaviour as above.
// TESTING
//   1. Reset, enable=1, s_valid=1 held -> ema_valid pulses every 4 cycles.
//      The first 64 pulses carry coef_warm; state=TRACK after the 64th.
//   2. TRACK, ema_level=100, s_data=50 -> ema_coeff=coef_release.
//      s_data=200 -> coef_attack, state=HOLD.
//   3. HOLD with HOLD_LEN=4 and s_data below level -> 4 issues with coeff=0, then state=TRACK.
//      An attack mid-hold reloads the count to 4.
//   4. restart pulse in TRACK coincident with an accepted sample ->
//      that sample uses coef_warm, state=WARMUP, warm_cnt=1.
//   5. enable dropped 1 cycle after accept -> that ema_valid still fires.
//      s_ready=0 thereafter; state=IDLE 4 cycles later.
//   6. Async reset asserted mid-gap -> all outputs 0 immediately; no further ema_valid.
//      With EMA_SEQ_FREEZE_EN: freeze=1 gives coeff=0 and warm_cnt frozen.

Source files
------------

// File: rtl/ema_coeff_sequencer_if.sv
// Sample stream into the sequencer and issue bus out to the EMA datapath.
// The slave modport is the sequencer side; master is the producer/consumer side.
interface ema_coeff_sequencer_if #(
  parameter int DWIDTH = 27,
  parameter int BWIDTH = 18
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DWIDTH-1:0] s_data;
  logic                     ema_valid;
  logic signed [DWIDTH-1:0] ema_data;
  logic        [BWIDTH-1:0] ema_coeff;

  modport slave (
    input  s_valid, s_data,
    output s_ready, ema_valid, ema_data, ema_coeff
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, ema_valid, ema_data, ema_coeff
  );
endinterface

// File: rtl/ema_coeff_sequencer.sv
// Throttles samples into the EMA and picks the warm-up/attack/hold/release coefficient.
// Optional EMA_SEQ_FREEZE_EN adds a freeze input that issues samples with coefficient 0.
module ema_coeff_sequencer #(
  parameter int DWIDTH     = 27,
  parameter int BWIDTH     = 18,
  parameter int OUTWIDTH   = 48,
  parameter int WARMUP_LEN = 64,
  parameter int HOLD_LEN   = 256,
  parameter int ISSUE_GAP  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                restart,
`ifdef EMA_SEQ_FREEZE_EN
  input  logic                freeze,
`endif
  input  logic [BWIDTH-1:0]   coef_warm,
  input  logic [BWIDTH-1:0]   coef_attack,
  input  logic [BWIDTH-1:0]   coef_release,
  input  logic [OUTWIDTH-1:0] ema_level,
  ema_coeff_sequencer_if.slave sif,
  output logic [1:0]          state
);

  localparam int WCW = $clog2(WARMUP_LEN + 1);
  localparam int HCW = $clog2(HOLD_LEN + 1);
  localparam int GCW = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_TRACK  = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [WCW-1:0]           warm_cnt, warm_d;
  logic [HCW-1:0]           hold_cnt, hold_d;
  logic [GCW-1:0]           gap_cnt;
  logic [BWIDTH-1:0]        coef_d;
  logic                     vld_p1;
  logic signed [DWIDTH-1:0] data_p1;
  logic [BWIDTH-1:0]        coef_p1;
  logic signed [DWIDTH-1:0] lvl_lo;
  logic                     accept, attack, frz;
  logic                     unused_level_msbs;

  function automatic logic [WCW-1:0] warm_inc(input logic [WCW-1:0] c);
    return (c >= WCW'(WARMUP_LEN)) ? c : c + 1'b1;
  endfunction

  function automatic logic [HCW-1:0] hold_dec(input logic [HCW-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

`ifdef EMA_SEQ_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif

  // Only the low DWIDTH bits of the EMA output share the sample's scale.
  assign lvl_lo            = ema_level[DWIDTH-1:0];
  assign unused_level_msbs = ^ema_level[OUTWIDTH-1:DWIDTH];
  assign attack            = sif.s_data > lvl_lo;

  assign sif.s_ready = enable && (state_q != S_IDLE) && (gap_cnt == '0);
  assign accept      = sif.s_valid && sif.s_ready;

  always_comb begin
    state_d = state_q;
    warm_d  = warm_cnt;
    hold_d  = hold_cnt;
    coef_d  = coef_p1;
    if (state_q == S_IDLE) begin
      if (enable) begin
        state_d = S_WARMUP;
        warm_d  = '0;
        hold_d  = '0;
      end
    end else if (!enable) begin
      if (gap_cnt == '0) state_d = S_IDLE;
    end else begin
      if (restart) begin
        state_d = S_WARMUP;
        warm_d  = '0;
        hold_d  = '0;
      end
      if (accept) begin
        // A restart turns the coincident sample into the first warm-up sample.
        if (restart || (state_q == S_WARMUP && !frz)) begin
          warm_d  = warm_inc(restart ? '0 : warm_cnt);
          coef_d  = coef_warm;
          state_d = (warm_d >= WCW'(WARMUP_LEN)) ? S_TRACK : S_WARMUP;
        end else if (frz) begin
          coef_d = '0;
        end else if (attack) begin
          coef_d  = coef_attack;
          hold_d  = HCW'(HOLD_LEN);
          state_d = S_HOLD;
        end else if (state_q == S_TRACK) begin
          coef_d = coef_release;
        end else begin
          coef_d = '0;
          hold_d = hold_dec(hold_cnt);
          if (hold_d == '0) state_d = S_TRACK;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      warm_cnt <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      warm_cnt <= warm_d;
      hold_cnt <= hold_d;
      if (accept)               gap_cnt <= GCW'(ISSUE_GAP - 1);
      else if (gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Issue stage: sample and its coefficient land together, one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      coef_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= sif.s_data;
        coef_p1 <= coef_d;
      end
    end
  end

  assign sif.ema_valid = vld_p1;
  assign sif.ema_data  = data_p1;
  assign sif.ema_coeff = coef_p1;
  assign state         = state_q;

endmodule
